// File: rtl/mult_sched_pkg.sv
// Shared constants and types for the two-requester multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned FRAME_DEF = 32;
  localparam int unsigned CNT_W_DEF = $clog2(FRAME_DEF);

  // Requester index: 0 or 1
  typedef logic [0:0] req_id_t;

  // Operation owned by a multiplier frame
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } owner_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mult_scheduler_arb2.sv
// Two-way arbiter: a lone request always wins; on conflict the requester
// other than ptr (the last one granted) wins.
module arb2
  import mult_sched_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    ptr,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr[0] ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mult_scheduler.sv
// Time-shares one frame-based multiplier between two requesters.
// Each frame of FRAME cycles computes one product; operands are granted at
// the end of the previous frame and the result is returned at the start of
// the next one. Build option: define MULT_SCHED_ROUNDROBIN_EN for
// round-robin conflict resolution; otherwise req0 has fixed priority.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FRAME = FRAME_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         ack,
  output logic [1:0]         done,
  output logic [2*WIDTH-1:0] res,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_sy,
  input  logic [2*WIDTH-1:0] mul_p
);

  localparam int unsigned   CW       = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(FRAME - 2);

  logic [CW-1:0]    cnt;
  logic             dec_edge;
  logic             last_edge;
  logic [1:0]       grant;
  req_id_t          ptr;
  req_id_t          gnt_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  owner_t           own_acc;   // op whose operands are being presented
  owner_t           own_cmp;   // op the multiplier is computing this frame

  assign dec_edge  = (cnt == CNT_DEC);
  assign last_edge = (cnt == CNT_LAST);
  assign gnt_id    = grant[1];

  arb2 u_arb (
    .req   ({req1, req0}),
    .ptr   (ptr),
    .grant (grant)
  );

`ifdef MULT_SCHED_ROUNDROBIN_EN
  req_id_t last_id;

  // Remember the most recently granted requester; moves only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (dec_edge && (grant != 2'b00)) begin
      last_id <= gnt_id;
    end
  end

  assign ptr = last_id;
`else
  // Pretending requester 1 was always granted last makes req0 win every tie
  assign ptr = 1'b1;
`endif

  // Operands of the granted requester, zero when the frame is idle
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (grant[0]) begin
      sel_a = a0;
      sel_b = b0;
    end else if (grant[1]) begin
      sel_a = a1;
      sel_b = b1;
    end
  end

  // Frame counter; reset to the last count so the first edge opens frame 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= CNT_LAST;
      mul_sy <= 1'b0;
    end else begin
      cnt    <= last_edge ? '0 : cnt + CW'(1);
      mul_sy <= 1'b1;
    end
  end

  // Decision edge: latch operands, pulse ack, record frame owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      ack     <= '0;
      own_acc <= '0;
    end else begin
      ack <= '0;
      if (dec_edge) begin
        mul_a         <= sel_a;
        mul_b         <= sel_b;
        ack           <= grant;
        own_acc.valid <= (grant != 2'b00);
        own_acc.id    <= gnt_id;
      end
    end
  end

  // Frame boundary: retire the computing op and advance the owner pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_cmp <= '0;
      res     <= '0;
      done    <= '0;
    end else begin
      done <= '0;
      if (last_edge) begin
        own_cmp <= own_acc;
        if (own_cmp.valid) begin
          res  <= mul_p;
          done <= id_onehot(own_cmp.id);
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: frame-based multiplier stand-in, event-queue
// reference model, directed scenarios and a randomized phase.
module tb_mult_scheduler;

  localparam int W = 16;
  localparam int F = 32;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0  = 1'b0;
  logic           req1  = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]     ack, done;
  logic [2*W-1:0] res;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_sy;
  logic [2*W-1:0] mul_p = '0;

  int n_checks = 0;
  int n_err    = 0;

  // reference model outputs
  int             k = 0;          // clock edges since reset release
  logic [1:0]     exp_ack  = '0;
  logic [1:0]     exp_done = '0;
  logic [2*W-1:0] exp_res  = '0;
  logic [W-1:0]   exp_a    = '0;
  logic [W-1:0]   exp_b    = '0;
  logic           exp_sy   = 1'b0;

  typedef struct {
    int             due;
    logic [1:0]     oh;
    logic [2*W-1:0] prod;
  } op_t;
  op_t pend[$];

  mult_scheduler #(.WIDTH(W), .FRAME(F)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .ack    (ack),
    .done   (done),
    .res    (res),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_sy (mul_sy),
    .mul_p  (mul_p)
  );

  initial forever #5 clk = ~clk;

  // Multiplier stand-in: latches operands in frame cycle 0, shows the product
  // only during the last frame cycle and noise otherwise.
  initial begin : mult_env
    int cur;
    int nxt;
    logic [2*W-1:0] mprod;
    nxt   = 0;
    cur   = 0;
    mprod = '0;
    forever begin
      @(negedge clk);
      if (mul_sy) begin
        cur = nxt;
        nxt = (cur + 1) % F;
        if (cur == 0) mprod = (2*W)'(mul_a) * (2*W)'(mul_b);
        mul_p = (cur == F - 1) ? mprod : (2*W)'($urandom);
      end else begin
        nxt   = 0;
        mul_p = (2*W)'($urandom);
      end
    end
  end

  // Reference model: decision every F edges, result due F+1 edges later.
  initial begin : ref_model
`ifdef MULT_SCHED_ROUNDROBIN_EN
    int last_id;
    last_id = 1;
`endif
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0; exp_ack = '0; exp_done = '0; exp_res = '0;
        exp_a = '0; exp_b = '0; exp_sy = 1'b0;
        pend.delete();
`ifdef MULT_SCHED_ROUNDROBIN_EN
        last_id = 1;
`endif
      end else begin
        int g;
        k++;
        exp_sy = 1'b1; exp_ack = '0; exp_done = '0;
        if (k % F == 0) begin
          g = -1;
          if (req0 && req1) begin
`ifdef MULT_SCHED_ROUNDROBIN_EN
            g = (last_id == 1) ? 0 : 1;
`else
            g = 0;
`endif
          end else if (req0) g = 0;
          else if (req1) g = 1;
          exp_a = (g == 0) ? a0 : (g == 1) ? a1 : '0;
          exp_b = (g == 0) ? b0 : (g == 1) ? b1 : '0;
          if (g >= 0) begin
            exp_ack = 2'(1 << g);
`ifdef MULT_SCHED_ROUNDROBIN_EN
            last_id = g;
`endif
            pend.push_back('{k + F + 1, 2'(1 << g), (2*W)'(exp_a) * (2*W)'(exp_b)});
          end
        end
        if (pend.size() > 0 && pend[0].due == k) begin
          exp_done = pend[0].oh;
          exp_res  = pend[0].prod;
          pend.delete(0);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", nm, act, expv, k, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model
  task automatic tick();
    @(negedge clk);
    chk("ack",    64'(ack),    64'(exp_ack));
    chk("done",   64'(done),   64'(exp_done));
    chk("res",    64'(res),    64'(exp_res));
    chk("mul_a",  64'(mul_a),  64'(exp_a));
    chk("mul_b",  64'(mul_b),  64'(exp_b));
    chk("mul_sy", 64'(mul_sy), 64'(exp_sy));
    chk("onehot", 64'(($countones(ack) <= 1) && ($countones(done) <= 1)), 64'd1);
  endtask

  // Wait (bounded) for ack/done bit; reports k at which it was seen, or -1
  task automatic wait_sig(input bit is_done, input int bitn, input int limit,
                          input string nm, output int at_k);
    at_k = -1;
    for (int c = 0; c < limit; c++) begin
      tick();
      if ((is_done ? done[bitn] : ack[bitn]) == 1'b1) begin
        at_k = k;
        break;
      end
    end
    chk({nm, "_seen"}, 64'(at_k >= 0), 64'd1);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ack"},   64'(ack),    64'd0);
    chk({nm, "_done"},  64'(done),   64'd0);
    chk({nm, "_res"},   64'(res),    64'd0);
    chk({nm, "_mul_a"}, 64'(mul_a),  64'd0);
    chk({nm, "_mul_b"}, 64'(mul_b),  64'd0);
    chk({nm, "_sy"},    64'(mul_sy), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : main
    int ka, kd, ka0, ka1, kd0, kd1, kb, n, cnt_bad;
    logic [1:0] seq [4];

    // reset state
    tick();
    chk_zero_outputs("reset");
    tick();
    #2 rst_n = 1'b1;

    // single op 12*75
    req0 = 1'b1; a0 = 16'd12; b0 = 16'd75;
    wait_sig(1'b0, 0, 3 * F, "t1_ack", ka);
    req0 = 1'b0;
    chk("t1_ack_k", 64'(ka), 64'd32);
    wait_sig(1'b1, 0, 3 * F, "t1_done", kd);
    chk("t1_latency", 64'(kd - ka), 64'(F + 1));
    chk("t1_res", 64'(res), 64'd900);

    // simultaneous requests
    req0 = 1'b1; a0 = 16'd16; b0 = 16'd5;
    req1 = 1'b1; a1 = '1;     b1 = '1;
    ka0 = -1; ka1 = -1; kd0 = -1; kd1 = -1;
    for (int c = 0; c < 5 * F && !(kd0 >= 0 && kd1 >= 0); c++) begin
      tick();
      if (ack[0]) begin ka0 = k; req0 = 1'b0; end
      if (ack[1]) begin ka1 = k; req1 = 1'b0; end
      if (done[0]) begin kd0 = k; chk("t3_res0", 64'(res), 64'd80); end
      if (done[1]) begin kd1 = k; chk("t3_res1", 64'(res), 64'h0000_0000_FFFE_0001); end
    end
    chk("t3_ack_gap",  64'(ka1 - ka0), 64'(F));
    chk("t3_done_gap", 64'(kd1 - kd0), 64'(F));
    chk("t3_lat0",     64'(kd0 - ka0), 64'(F + 1));

    // both held for four decisions
    req0 = 1'b1; a0 = 16'd3; b0 = 16'd4;
    req1 = 1'b1; a1 = 16'd5; b1 = 16'd6;
    n = 0;
    for (int c = 0; c < 6 * F && n < 4; c++) begin
      tick();
      if (ack != 2'b00) begin
        seq[n] = ack;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t4_count", 64'(n), 64'd4);
`ifdef MULT_SCHED_ROUNDROBIN_EN
    chk("t4_seq0", 64'(seq[0]), 64'b01);
    chk("t4_seq1", 64'(seq[1]), 64'b10);
    chk("t4_seq2", 64'(seq[2]), 64'b01);
    chk("t4_seq3", 64'(seq[3]), 64'b10);
`else
    for (int i = 0; i < 4; i++) chk("t4_seq_fixed", 64'(seq[i]), 64'b01);
`endif
    for (int c = 0; c < 2 * F; c++) tick();

    // request arriving just after the decision edge
    kb = -1;
    for (int c = 0; c < 2 * F; c++) begin
      tick();
      if (k % F == 0) begin kb = k; break; end
    end
    req0 = 1'b1; a0 = 16'd7; b0 = 16'd9;
    wait_sig(1'b0, 0, 3 * F, "t5_ack", ka);
    req0 = 1'b0;
    chk("t5_wait_frame", 64'(ka - kb), 64'(F));
    wait_sig(1'b1, 0, 3 * F, "t5_done", kd);
    chk("t5_res", 64'(res), 64'd63);

    // reset mid-computation
    req0 = 1'b1; a0 = 16'd100; b0 = 16'd200;
    wait_sig(1'b0, 0, 3 * F, "t6_ack", ka);
    req0 = 1'b0;
    for (int c = 0; c < 2 * F && k < ka + 11; c++) tick();
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("t6_rst");
    tick();
    #2 rst_n = 1'b1;
    cnt_bad = 0;
    for (int c = 0; c < 3 * F; c++) begin
      tick();
      if (done != 2'b00) cnt_bad++;
    end
    chk("t6_no_done", 64'(cnt_bad), 64'd0);
    req1 = 1'b1; a1 = 16'd3; b1 = 16'd7;
    wait_sig(1'b0, 1, 3 * F, "t6_ack1", ka);
    req1 = 1'b0;
    wait_sig(1'b1, 1, 3 * F, "t6_done1", kd);
    chk("t6_res", 64'(res), 64'd21);

    // idle frames
    for (int c = 0; c < F + 4; c++) tick();
    cnt_bad = 0;
    for (int c = 0; c < 3 * F; c++) begin
      tick();
      if (ack != 2'b00 || done != 2'b00 || mul_a != '0 || mul_b != '0 || mul_sy != 1'b1)
        cnt_bad++;
    end
    chk("t7_idle", 64'(cnt_bad), 64'd0);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (ack[0]) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else begin a0 = rnd_op(); b0 = rnd_op(); end
      end else if (!req0 && $urandom_range(0, 15) == 0) begin
        req0 = 1'b1; a0 = rnd_op(); b0 = rnd_op();
      end
      if (ack[1]) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else begin a1 = rnd_op(); b1 = rnd_op(); end
      end else if (!req1 && $urandom_range(0, 15) == 0) begin
        req1 = 1'b1; a1 = rnd_op(); b1 = rnd_op();
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 3 * F; c++) tick();
    chk("drain_empty", 64'(pend.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
